// File: rtl/demap_bit_fifo.sv
// Bit-serial FIFO fed by 1/2/4-bit demapped symbols, drained one bit per read.
// Optional sticky ovf/udf error flags are enabled with DEMAP_FIFO_ERR_EN.
module demap_bit_fifo #(
  parameter int ADDR_W  = 10,
  parameter int MAX_BPS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               flush,
  input  logic               we,
  input  logic [MAX_BPS-1:0] data_in,
  input  logic               re,
`ifdef DEMAP_FIFO_ERR_EN
  input  logic               err_clr,
  output logic               ovf,
  output logic               udf,
`endif
  output logic               data_out,
  output logic               valid_out,
  output logic               wr_rdy,
  output logic               empty,
  output logic [ADDR_W:0]    count
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic              r_mem [1<<ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_data_out;
  logic              r_valid_out;

  logic [2:0]        w_bps;
  logic [ADDR_W:0]   w_bps_c;
  logic [ADDR_W:0]   w_free;
  logic              w_wr_rdy;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  always_comb begin
    w_bps = 3'd0;
    unique case (1'b1)
      (mode == 2'b00): w_bps = 3'd1;
      (mode == 2'b01): w_bps = 3'd2;
      (mode == 2'b10): w_bps = 3'd4;
      (mode == 2'b11): w_bps = 3'd0;
    endcase
  end

  assign w_bps_c  = (ADDR_W+1)'(w_bps);
  assign w_free   = DEPTH_C - r_count;
  // reserved mode never reports space so it can't look writable
  assign w_wr_rdy = (mode != 2'b11) && (w_free >= w_bps_c);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = we & ~flush & w_wr_rdy;
  assign w_rd_acc = re & ~flush & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < MAX_BPS; i++) begin
        if (i < int'(w_bps))
          r_mem[r_wr_ptr + ADDR_W'(i)] <= data_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= 1'b0;
      r_valid_out <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(w_bps);
      r_count <= r_count
               + (w_wr_acc ? w_bps_c : '0)
               - (ADDR_W+1)'(w_rd_acc);
    end
  end

`ifdef DEMAP_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = we & ~flush & ~w_wr_rdy;
  assign w_udf_set = re & ~flush & w_empty;

  // set has priority over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
      r_udf <= w_udf_set | (r_udf & ~err_clr);
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`endif

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign wr_rdy    = w_wr_rdy;
  assign empty     = w_empty;
  assign count     = r_count;

endmodule

// File: tb/tb_demap_bit_fifo.sv
// Scoreboard bench for demap_bit_fifo (DEPTH 8) against a bit-queue model.
// Error-flag checks are compiled in with DEMAP_FIFO_ERR_EN.
module tb_demap_bit_fifo;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  typedef struct {
    bit b;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          flush = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    data_in = 4'h0;
  logic          re = 1'b0;
  logic          data_out;
  logic          valid_out;
  logic          wr_rdy;
  logic          empty;
  logic [AW:0]   count;
`ifdef DEMAP_FIFO_ERR_EN
  logic          err_clr = 1'b0;
  logic          ovf;
  logic          udf;
  bit            m_ovf;
  bit            m_udf;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   q[$];
  exp_t expq[$];

  demap_bit_fifo #(.ADDR_W(AW), .MAX_BPS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .flush     (flush),
    .we        (we),
    .data_in   (data_in),
    .re        (re),
`ifdef DEMAP_FIFO_ERR_EN
    .err_clr   (err_clr),
    .ovf       (ovf),
    .udf       (udf),
`endif
    .data_out  (data_out),
    .valid_out (valid_out),
    .wr_rdy    (wr_rdy),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bps(input logic [1:0] m);
    case (m)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, req, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a bit
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid_out) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: got data_out %0d expected no output at cycle %0d",
                 data_out, cyc);
      end else begin
        e = expq.pop_front();
        if (e.b != data_out || e.cyc != cyc) begin
          errors++;
          $display("FAIL read_bit: got %0d at cycle %0d expected %0d at cycle %0d",
                   data_out, cyc, e.b, e.cyc);
        end
      end
    end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = expq.pop_front();
      $display("FAIL missing_valid: got valid_out 0 expected bit %0d at cycle %0d",
               e.b, e.cyc);
    end
  end

  task automatic step(input bit i_we, input logic [1:0] i_mode,
                      input logic [3:0] i_din, input bit i_re,
                      input bit i_fl, input bit i_clr);
    bit rd;
    bit wok;
    int n;
    @(negedge clk);
    we = i_we; mode = i_mode; data_in = i_din;
    re = i_re; flush = i_fl;
`ifdef DEMAP_FIFO_ERR_EN
    err_clr = i_clr;
`endif
    #1;
    n = q.size();
    check("count", int'(count), n);
    check("empty", int'(empty), int'(n == 0));
    if (i_mode != 2'b11)
      check("wr_rdy", int'(wr_rdy), int'(DEPTH - n >= bps(i_mode)));
`ifdef DEMAP_FIFO_ERR_EN
    check("ovf", int'(ovf), int'(m_ovf));
    check("udf", int'(udf), int'(m_udf));
`endif
    wok = i_we && i_mode != 2'b11 && (DEPTH - n >= bps(i_mode));
    rd  = i_re && n > 0;
    if (i_fl) begin
      q.delete();
    end else begin
      if (rd) expq.push_back('{b: q.pop_front(), cyc: cyc + 1});
      if (wok)
        for (int i = 0; i < bps(i_mode); i++) q.push_back(i_din[i]);
    end
`ifdef DEMAP_FIFO_ERR_EN
    if (!i_fl && i_we && !wok) m_ovf = 1'b1;
    else if (i_clr)            m_ovf = 1'b0;
    if (!i_fl && i_re && n == 0) m_udf = 1'b1;
    else if (i_clr)              m_udf = 1'b0;
`endif
  endtask

  task automatic wr(input logic [1:0] m, input logic [3:0] d);
    step(1'b1, m, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    step(1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) rd1();
    idle();
  endtask

  initial begin
    #2;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_valid", int'(valid_out), 0);
    check("rst_dout", int'(data_out), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int m = 0; m < 3; m++) step(1'b0, 2'(m), 4'h0, 1'b0, 1'b0, 1'b0);

    // 16QAM symbol read back bit by bit
    wr(2'b10, 4'b1011);
    for (int k = 0; k < 4; k++) rd1();
    idle();

    // fill to full with BPSK, ninth write dropped
    for (int k = 0; k < 9; k++) wr(2'b00, 4'($urandom_range(0, 1)));
    drain();

    // pointers parked at 6, then wrap with mixed widths
    do_flush();
    for (int k = 0; k < 6; k++) wr(2'b00, 4'($urandom_range(0, 1)));
    drain();
    wr(2'b01, 4'b0010);
    wr(2'b10, 4'b0110);
    drain();

    // concurrent QPSK writes and reads from count 3
    do_flush();
    for (int k = 0; k < 3; k++) wr(2'b00, 4'($urandom_range(0, 1)));
    for (int k = 0; k < 3; k++)
      step(1'b1, 2'b01, 4'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
    drain();

    // flush overrides we/re, then read on empty
    wr(2'b10, 4'b1100);
    wr(2'b00, 4'b0001);
    step(1'b1, 2'b10, 4'hF, 1'b1, 1'b1, 1'b0);
    rd1();
    idle();
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    idle();

    // reset with a read in flight
    wr(2'b10, 4'b0101);
    rd1();
    @(posedge clk);
    #3;
    reset = 1'b0;
    q.delete();
    expq.delete();
`ifdef DEMAP_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
    #1;
    check("mid_rst_valid", int'(valid_out), 0);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(empty), 1);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    idle();

    // randomized traffic
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0));
    drain();
    idle();
    check("scoreboard_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule

// File: doc/demap_bit_fifo.md
DEMAP_BIT_FIFO -- requirements
Module: demap_bit_fifo

Interface
REQ-001 Parameter ADDR_W, default 10: bit-storage address width; DEPTH = 2^ADDR_W bits.
REQ-002 Parameter MAX_BPS, default 4: widest write symbol in bits; fixed at 4 in this generation.
REQ-003 The clock port SHALL be clk; reset is asynchronous and active-low (port reset).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mode  input  2  per-write demapper mode: 00 BPSK (1 bit), 01 QPSK (2 bits), 10 16QAM (4 bits), 11 reserved.
REQ-007 flush  input  1  synchronous clear of all stored bits.
REQ-008 we  input  1  write request for one demapped symbol.
REQ-009 data_in  input  MAX_BPS  symbol bits; bit 0 is first-out, only the low bps(mode) bits are used.
REQ-010 re  input  1  read request for one bit.
REQ-011 data_out  output  1  registered serial bit.
REQ-012 valid_out  output  1  one-cycle strobe qualifying data_out.
REQ-013 wr_rdy  output  1  high when free space >= bps(mode).
REQ-014 empty  output  1  high when count == 0.
REQ-015 count  output  ADDR_W+1  stored bits, 0..DEPTH.

Function
REQ-016 Storage SHALL be a DEPTH x 1-bit circular buffer with wr_ptr and rd_ptr of ADDR_W bits, wrapping DEPTH-1 -> 0.
REQ-017 A write SHALL be accepted when we=1, mode!=11, flush=0 and wr_rdy=1; bits data_in[0..bps-1] go to wr_ptr, wr_ptr+1, ... modulo DEPTH; wr_ptr advances by bps.
REQ-018 A write with wr_rdy=0 or mode=11 SHALL be dropped entirely (no partial symbol stored).
REQ-019 A read SHALL be accepted when re=1, flush=0 and count>0 (count sampled before the cycle's write); rd_ptr advances by 1.
REQ-020 data_out SHALL present the bit at the pre-increment rd_ptr and valid_out SHALL pulse high exactly one cycle after each accepted read (latency 1); otherwise valid_out=0 and data_out holds.
REQ-021 re with empty=1 SHALL be ignored; a bit written in cycle N is readable no earlier than cycle N+1.
REQ-022 Simultaneous accepted read and write SHALL update count by bps-1 in one cycle; wr_rdy uses pre-cycle free space (no read-through credit).
REQ-023 flush=1 SHALL zero wr_ptr, rd_ptr and count next cycle and override we/re that cycle; valid_out=0 the following cycle.
REQ-024 mode MAY change between writes; symbols of different widths interleave bit-exactly in FIFO order.
REQ-025 wr_rdy, empty and count SHALL be combinational functions of registered state and mode only.

Reset
REQ-026 reset=0 SHALL asynchronously set wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0; storage contents are undefined.
REQ-027 Reset asserted mid-operation SHALL discard all buffered bits and any read in flight (no valid_out after release).
REQ-028 After reset release, empty=1 and wr_rdy=1 for every legal mode.

Configuration
REQ-029 Macro DEMAP_FIFO_ERR_EN: when defined, adds input err_clr (1) and outputs ovf (1), udf (1).
REQ-030 With DEMAP_FIFO_ERR_EN: ovf sets on any dropped write (REQ-018), udf sets on re with empty=1; both sticky until err_clr=1 or reset; set wins over simultaneous clear.
REQ-031 Without DEMAP_FIFO_ERR_EN: ports err_clr, ovf, udf absent; drops and empty reads are silent; all other behaviour identical.

Verification
REQ-032 Reset, mode=10, write 4'b1011, then 4 reads -> data_out 1,1,0,1 on consecutive valid_out pulses; count 4->0; empty=1.
REQ-033 ADDR_W=3: write 8 BPSK bits, count=8, wr_rdy=0; 9th write dropped (ovf=1 with macro); reads return the 8 bits in order.
REQ-034 ADDR_W=3, pointers at 6: QPSK write 2'b10 then 16QAM write 4'b0110 -> wrap correct; read order 0,1,0,1,1,0.
REQ-035 count=3, mode=01, simultaneous write and read each cycle -> count 4,5,6; valid_out each cycle after first read.
REQ-036 count=5, assert flush with we=1, re=1 -> next cycle count=0, empty=1, no valid_out; re on empty -> no valid_out, udf=1 with macro.
REQ-037 Assert reset mid-stream with read in flight -> valid_out=0, count=0 immediately; no stale valid_out after release.
